// File: rtl/coreTypes.sv
// Shared core types: branch-history counter states, fetch constants and the
// saturating counter update used by the predictor.
package coreTypes;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bhtState_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic bhtState_t bht_train(input bhtState_t cur, input logic taken);
    bhtState_t nxt;
    case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branchPredictor.sv
// Direct-mapped BTB with 2-bit bimodal counters: combinational lookup on the
// fetch PC, trained from execute-stage branch resolution (no read bypass).
module branchPredictor
  import coreTypes::*;
#(
  parameter int IDX_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  output logic        predTaken,
  output logic [31:0] predTarget,
  input  logic        resolveE,
  input  logic        takenE,
  input  logic [31:0] pcE,
  input  logic [31:0] targetE
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 32 - IDX_W - 2;

  logic             valid_r  [ENTRIES];
  logic [TAG_W-1:0] tag_r    [ENTRIES];
  logic [29:0]      target_r [ENTRIES];
  bhtState_t        ctr_r    [ENTRIES];

  logic [IDX_W-1:0] rd_idx_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [TAG_W-1:0] wr_tag_s;
  logic             wr_hit_s;
  logic             unused_bits_s;

  assign rd_idx_s = pcF[IDX_W+1:2];
  assign rd_tag_s = pcF[31:IDX_W+2];
  assign wr_idx_s = pcE[IDX_W+1:2];
  assign wr_tag_s = pcE[31:IDX_W+2];

  assign predTaken  = valid_r[rd_idx_s] && (tag_r[rd_idx_s] == rd_tag_s) && ctr_r[rd_idx_s][1];
  assign predTarget = {target_r[rd_idx_s], 2'b00};
  assign wr_hit_s   = valid_r[wr_idx_s] && (tag_r[wr_idx_s] == wr_tag_s);

  // Byte-offset bits carry no information for word-aligned fetch.
  assign unused_bits_s = ^{pcF[1:0], pcE[1:0], targetE[1:0]};

  // Table training: hits move the counter, taken misses allocate weakly-taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= {TAG_W{1'b0}};
        target_r[i] <= 30'd0;
        ctr_r[i]    <= WNT;
      end
    end else if (resolveE) begin
      if (wr_hit_s) begin
        ctr_r[wr_idx_s] <= bht_train(ctr_r[wr_idx_s], takenE);
        if (takenE) begin
          target_r[wr_idx_s] <= targetE[31:2];
        end
      end else if (takenE) begin
        valid_r[wr_idx_s]  <= 1'b1;
        tag_r[wr_idx_s]    <= wr_tag_s;
        target_r[wr_idx_s] <= targetE[31:2];
        ctr_r[wr_idx_s]    <= WT;
      end
    end
  end

endmodule

// File: rtl/stage_fetch.sv
// Instruction fetch stage: PC register, prioritised next-PC selection and
// combinational instruction-memory wiring around the branch predictor.
module stage_fetch
  import coreTypes::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IDX_W    = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirectE,
  input  logic [31:0] redirectPcE,
  input  logic        resolveE,
  input  logic        takenE,
  input  logic [31:0] pcE,
  input  logic [31:0] targetE,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemData,
  output logic [31:0] instrF,
  output logic [31:0] pcF,
  output logic [31:0] pcPlus4F,
  output logic        bPredictedTakenF
);

  logic [31:0] pc_r;
  logic [31:0] pc_next_s;
  logic [31:0] pred_target_s;
  logic        pred_taken_s;
  logic        unused_bits_s;

  branchPredictor #(.IDX_W(IDX_W)) u_bp (
    .clk        (clk),
    .rst        (rst),
    .pcF        (pc_r),
    .predTaken  (pred_taken_s),
    .predTarget (pred_target_s),
    .resolveE   (resolveE),
    .takenE     (takenE),
    .pcE        (pcE),
    .targetE    (targetE)
  );

  // Next-PC select: a redirect wins even over a stall.
  always_comb begin
    pc_next_s = pcPlus4F;
    if (redirectE) begin
      pc_next_s = {redirectPcE[31:2], 2'b00};
    end else if (stall) begin
      pc_next_s = pc_r;
    end else if (pred_taken_s) begin
      pc_next_s = pred_target_s;
    end else begin
      pc_next_s = pcPlus4F;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_next_s;
    end
  end

  assign pcF              = pc_r;
  assign pcPlus4F         = pc_r + 32'd4;
  assign imemAddr         = pc_r;
  assign instrF           = imemData;
  assign bPredictedTakenF = pred_taken_s;
  assign unused_bits_s    = ^redirectPcE[1:0];

endmodule

// File: tb/tb_stage_fetch.sv
// Self-checking bench for stage_fetch: directed vector table for the corner
// cases plus randomized traffic against an abstract predictor/PC model.
module tb_stage_fetch;

  localparam int          IDX_W = 6;
  localparam int          NENT  = 1 << IDX_W;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] IMEM_XOR = 32'hA5A5_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirectE, resolveE, takenE;
  logic [31:0] redirectPcE, pcE, targetE;
  logic [31:0] imemAddr, imemData, instrF, pcF, pcPlus4F;
  logic        bPredictedTakenF;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign imemData = imemAddr ^ IMEM_XOR;

  stage_fetch #(.RESET_PC(RPC), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .redirectE        (redirectE),
    .redirectPcE      (redirectPcE),
    .resolveE         (resolveE),
    .takenE           (takenE),
    .pcE              (pcE),
    .targetE          (targetE),
    .imemAddr         (imemAddr),
    .imemData         (imemData),
    .instrF           (instrF),
    .pcF              (pcF),
    .pcPlus4F         (pcPlus4F),
    .bPredictedTakenF (bPredictedTakenF)
  );

  // Reference model: plain arrays indexed by word address modulo table size.
  logic [31:0] m_pc;
  bit          m_valid [NENT];
  logic [31:0] m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_ctr   [NENT];

  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> 2) % NENT);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] a);
    return a >> (IDX_W + 2);
  endfunction

  function automatic logic m_pred(input logic [31:0] a);
    int i;
    i = m_idx(a);
    return m_valid[i] && (m_tag[i] == m_tagof(a)) && (m_ctr[i] >= 2);
  endfunction

  task automatic m_reset();
    m_pc = RPC;
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 32'd0;
      m_tgt[i]   = 32'd0;
      m_ctr[i]   = 1;
    end
  endtask

  task automatic m_train(input logic [31:0] a, input logic tk, input logic [31:0] t);
    int i;
    i = m_idx(a);
    if (m_valid[i] && m_tag[i] == m_tagof(a)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
        m_tgt[i] = t & ~32'd3;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (tk) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = m_tagof(a);
      m_tgt[i]   = t & ~32'd3;
      m_ctr[i]   = 2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_outputs();
    chk("pcF", pcF, m_pc);
    chk("pcPlus4F", pcPlus4F, m_pc + 32'd4);
    chk("imemAddr", imemAddr, m_pc);
    chk("instrF", instrF, m_pc ^ IMEM_XOR);
    chk("predTaken", {31'd0, bPredictedTakenF}, {31'd0, m_pred(m_pc)});
  endtask

  // One clock: model computes next state from pre-edge state, then compare.
  task automatic tick();
    logic [31:0] npc;
    if (redirectE)            npc = redirectPcE & ~32'd3;
    else if (stall)           npc = m_pc;
    else if (m_pred(m_pc))    npc = m_tgt[m_idx(m_pc)];
    else                      npc = m_pc + 32'd4;
    if (resolveE) m_train(pcE, takenE, targetE);
    @(posedge clk);
    @(negedge clk);
    m_pc = npc;
    check_outputs();
  endtask

  task automatic idle_inputs();
    stall = 1'b0; redirectE = 1'b0; redirectPcE = 32'd0;
    resolveE = 1'b0; takenE = 1'b0; pcE = 32'd0; targetE = 32'd0;
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      stall       = ($urandom_range(0, 7) == 0);
      redirectE   = ($urandom_range(0, 9) == 0);
      redirectPcE = 32'($urandom_range(0, 32'h7FF));
      resolveE    = ($urandom_range(0, 2) == 0);
      takenE      = ($urandom_range(0, 3) != 0);
      pcE         = ($urandom_range(0, 1) == 0) ? m_pc : (32'($urandom_range(0, 511)) << 2);
      targetE     = 32'($urandom_range(0, 32'h3FF));
      tick();
    end
  endtask

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        res;
    logic        tkn;
    logic [31:0] pce;
    logic [31:0] tgte;
    logic [31:0] exp_pc;
    logic        exp_pred;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                              input logic rs, input logic tk, input logic [31:0] pe,
                              input logic [31:0] te, input logic [31:0] ep, input logic ed);
    vec_t v;
    v.stall = s; v.redir = r; v.rpc = rp; v.res = rs; v.tkn = tk;
    v.pce = pe; v.tgte = te; v.exp_pc = ep; v.exp_pred = ed;
    return v;
  endfunction

  vec_t vecs[26];

  initial begin
    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h104,       0);
    vecs[1]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h108,       0);
    vecs[2]  = mk(0, 1, 32'h20,       0, 0, 32'h0,  32'h0,  32'h20,        0);
    vecs[3]  = mk(1, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h20,        0);
    vecs[4]  = mk(1, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h20,        0);
    vecs[5]  = mk(1, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h20,        0);
    vecs[6]  = mk(1, 1, 32'h83,       0, 0, 32'h0,  32'h0,  32'h80,        0);
    vecs[7]  = mk(0, 1, 32'h10,       1, 1, 32'h10, 32'h4,  32'h10,        1);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h4,         0);
    vecs[9]  = mk(0, 1, 32'h10,       1, 0, 32'h10, 32'h0,  32'h10,        0);
    vecs[10] = mk(1, 0, 32'h0,        1, 0, 32'h10, 32'h0,  32'h10,        0);
    vecs[11] = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h14,        0);
    vecs[12] = mk(1, 0, 32'h0,        1, 1, 32'h10, 32'h4,  32'h14,        0);
    vecs[13] = mk(1, 0, 32'h0,        1, 1, 32'h10, 32'h4,  32'h14,        0);
    vecs[14] = mk(1, 0, 32'h0,        1, 1, 32'h10, 32'h4,  32'h14,        0);
    vecs[15] = mk(1, 0, 32'h0,        1, 1, 32'h10, 32'h4,  32'h14,        0);
    vecs[16] = mk(1, 0, 32'h0,        1, 1, 32'h10, 32'h4,  32'h14,        0);
    vecs[17] = mk(0, 1, 32'h10,       1, 0, 32'h10, 32'h0,  32'h10,        1);
    vecs[18] = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h4,         0);
    vecs[19] = mk(0, 1, 32'h110,      0, 0, 32'h0,  32'h0,  32'h110,       0);
    vecs[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h114,       0);
    vecs[21] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'h0,  32'hFFFF_FFFC, 0);
    vecs[22] = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h0,         0);
    vecs[23] = mk(0, 0, 32'h0,        1, 1, 32'h0,  32'h40, 32'h4,         0);
    vecs[24] = mk(0, 1, 32'h0,        0, 0, 32'h0,  32'h0,  32'h0,         1);
    vecs[25] = mk(0, 0, 32'h0,        0, 0, 32'h0,  32'h0,  32'h40,        0);

    rst = 1'b0;
    idle_inputs();
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_pcF", pcF, 32'h100);
    chk("reset_pcPlus4F", pcPlus4F, 32'h104);
    check_outputs();
    rst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      stall = vecs[i].stall; redirectE = vecs[i].redir; redirectPcE = vecs[i].rpc;
      resolveE = vecs[i].res; takenE = vecs[i].tkn; pcE = vecs[i].pce; targetE = vecs[i].tgte;
      tick();
      chk($sformatf("vec%0d_pc", i), pcF, vecs[i].exp_pc);
      chk($sformatf("vec%0d_pred", i), {31'd0, bPredictedTakenF}, {31'd0, vecs[i].exp_pred});
      if (i == 21) chk("wrap_pcPlus4F", pcPlus4F, 32'h0);
    end

    idle_inputs();
    random_cycles(400);

    // Mid-operation reset with every control input active.
    stall = 1'b1; redirectE = 1'b1; redirectPcE = 32'h200;
    resolveE = 1'b1; takenE = 1'b1; pcE = RPC; targetE = 32'h300;
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk("midreset_pcF", pcF, RPC);
    chk("midreset_pred", {31'd0, bPredictedTakenF}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    idle_inputs();
    rst = 1'b1;
    random_cycles(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
# stage_fetch

Instruction fetch stage of the in-order RV32I core. It is the producer side of the fetch/decode pipeline interface and drives `instrF`, `pcF`, `pcPlus4F` and `bPredictedTakenF` into the decode pipeline registers. It owns the PC register and the next-PC selection, and drives a combinational-read instruction memory. It predicts branches with a direct-mapped branch target buffer (BTB) plus a 2-bit bimodal history table, trained from branch resolution in execute.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `IDX_W`, 6: predictor index width; 2^IDX_W BTB/BHT entries.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `stall` input 1: hazard unit hold; PC keeps its value.
- `redirectE` input 1: execute detected a misprediction; fetch restarts at `redirectPcE`.
- `redirectPcE` input 32: corrected fetch address.
- `resolveE` input 1: a conditional branch or JAL resolved in execute this cycle (JALR excluded).
- `takenE` input 1: resolved outcome.
- `pcE` input 32: PC of the resolved instruction.
- `targetE` input 32: resolved taken target.
- `imemAddr` output 32: instruction memory address, equal to `pcF`.
- `imemData` input 32: instruction word read combinationally at `imemAddr`.
- `instrF` output 32: equal to `imemData`.
- `pcF` output 32: current fetch PC.
- `pcPlus4F` output 32: `pcF + 4`, modulo 2^32.
- `bPredictedTakenF` output 1: fetch predicts taken for `pcF`.

## Operation
- Index is `pc[IDX_W+1:2]`. Tag is `pc[31:IDX_W+2]`.
- Each entry holds a valid bit, a tag, a 30-bit target (`target[31:2]`; target bits [1:0] are always 0) and a 2-bit counter.
- Counter encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Prediction (combinational on `pcF`): `bPredictedTakenF = valid & tag match & counter[1]`. The predicted target is the stored target.
- Next-PC priority, highest first:
  1. `redirectE` → `{redirectPcE[31:2],2'b00}`. A redirect overrides `stall`.
  2. `stall` → hold `pcF`.
  3. `bPredictedTakenF` → stored target.
  4. Otherwise → `pcPlus4F`.
- Training happens on `resolveE`, at entry `idx(pcE)`:
  - Tag hit: counter increments on taken (saturates at 11) and decrements on not-taken (saturates at 00). On taken, the target is rewritten with `targetE`.
  - Tag miss or invalid, and taken: allocate the entry. Set valid, tag from `pcE`, target from `targetE`, counter 10.
  - Tag miss or invalid, and not taken: no change.
- Training is not gated by `stall`.
- Same-cycle read/write of one index: the prediction uses the old contents (no bypass). The write is visible from the next cycle.
- PC arithmetic wraps modulo 2^32: `pcF` = 32'hFFFF_FFFC gives `pcPlus4F` = 0.

## Timing
- Reset (`rst` low, asynchronous):
  - `pcF` = `RESET_PC`.
  - All valid bits = 0 and all counters = 01.
  - As a result, `bPredictedTakenF` = 0, `pcPlus4F` = `RESET_PC + 4`, `imemAddr` = `RESET_PC`.
- Release from reset is synchronous to `clk`. The first fetch uses `RESET_PC` in the first cycle after release.
- The PC register updates on every rising edge according to the priority list. There is zero-cycle combinational latency from `pcF` to `instrF` and to `bPredictedTakenF`.
- `redirectE` asserted in cycle N gives `pcF = redirectPcE` in cycle N+1. Flushing of decode is the hazard unit's job, not this block's.
- A taken prediction in cycle N gives `pcF` = target in cycle N+1 (no bubble).
- A training update from `resolveE` in cycle N first affects prediction in cycle N+1.
- Reset asserted mid-operation clears all state immediately, regardless of `stall`, `redirectE` or `resolveE`.

## Structure
- Shared package `coreTypes`:
  - enum `bhtState_t` with values SNT/WNT/WT/ST = 00/01/10/11.
  - constant `NOP_INSTR` = 32'h0000_0013.
  - default `RESET_PC`.
- Sub-module `branchPredictor` contains the BTB/BHT arrays, the lookup port (`pcF` → hit/taken/target) and the update port (`resolveE`, `takenE`, `pcE`, `targetE`).
- The top level keeps only the PC register, the next-PC mux and the imem wiring.

## Test plan
- Reset: with `RESET_PC` = 32'h100, release reset with no stall. Required sequence: `pcF` = 100, 104, 108, `pcPlus4F` = `pcF`+4, `bPredictedTakenF` = 0 throughout.
- Stall and redirect priority:
  - With `pcF` = 0x20, hold `stall` for 3 cycles. Required: `pcF` stays 0x20.
  - Assert `redirectE` with `redirectPcE` = 0x83 while `stall` = 1. Required: next `pcF` = 0x80.
- Training:
  - Resolve `pcE` = 0x10 taken to `targetE` = 0x4. Required: when `pcF` reaches 0x10 the next cycle, `bPredictedTakenF` = 1 and next `pcF` = 0x4.
  - Then resolve 0x10 not-taken twice. Required: the counter reaches 00 and 0x10 predicts not-taken.
- Saturation: resolve 0x10 taken 5 times. Required: counter = 11. Then one not-taken gives 10, and 0x10 still predicts taken.
- Aliasing: train 0x10 taken, then fetch 0x10 + (4 << IDX_W), same index but a different tag. Required: `bPredictedTakenF` = 0 and next PC = +4.
- Wrap and same-cycle update:
  - `pcF` = 32'hFFFF_FFFC with no prediction. Required: next `pcF` = 0.
  - Resolve at the same index as `pcF` in the same cycle. Required: the current prediction uses the old entry and the next cycle uses the new one.
